// File: rtl/pbit_pkg.sv
// pbit_pkg
//   Shared definitions for the p-bit update scheduler: the field and tanh
//   word widths, the Galois LFSR tap mask, the scheduler state encoding and
//   the one-step LFSR function used by pbit_lfsr32.
package pbit_pkg;

  localparam int          FIELD_W   = 6;
  localparam int          TANH_W    = 32;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    DECIDE,
    FIN
  } sched_state_t;

  // Right-shifting Galois step for x^32+x^22+x^2+x+1. When the bit that
  // falls out is set, the tap mask is folded back in.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/pbit_lfsr32.sv
// pbit_lfsr32
//   32-bit Galois LFSR that supplies the uniform random numbers for the
//   p-bit decisions. It advances one step per cycle while en is high.
//   A zero seed would lock the register at zero, so it is replaced by 1.
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, loads the seed
//   en     in   advance one step this cycle
//   q      out  current LFSR state (never zero)
module pbit_lfsr32
  import pbit_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] q
);

  localparam logic [31:0] SEED_FIX = (SEED == 32'h0) ? 32'h1 : SEED;

  // The register only moves when enabled, so the random stream is
  // consumed exactly once per p-bit lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED_FIX;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/pbit_update_sched.sv
// pbit_update_sched
//   Gibbs-order update scheduler for N_PBITS p-bits sharing one tanh LUT.
//   Each p-bit takes two cycles: LOOKUP drives its local field to the LUT
//   and captures the result, DECIDE compares that result against a signed
//   uniform random number and writes the new p-bit state. After the
//   programmed number of sweeps (or a halt) a one-cycle done pulse follows.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run (only looked at while idle)
//   halt       in   end the run after the current DECIDE cycle
//   sweeps     in   number of full sweeps, captured with start
//   field_in   in   flattened local fields, p-bit k at [6k+5:6k]
//   tanh_addr  out  address to the shared tanh LUT
//   tanh_data  in   combinational tanh result, +/-2^30 full scale
//   m_out      out  p-bit states (1 = +1, 0 = -1)
//   sel_idx    out  p-bit currently being updated
//   busy       out  run in progress
//   done       out  one-cycle pulse at end of run
module pbit_update_sched
  import pbit_pkg::*;
#(
  parameter int          N_PBITS   = 8,
  parameter int          IDX_W     = $clog2(N_PBITS),
  parameter logic [31:0] LFSR_SEED = 32'h1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       halt,
  input  logic [15:0]                sweeps,
  input  logic [FIELD_W*N_PBITS-1:0] field_in,
  output logic [FIELD_W-1:0]         tanh_addr,
  input  logic [TANH_W-1:0]          tanh_data,
  output logic [N_PBITS-1:0]         m_out,
  output logic [IDX_W-1:0]           sel_idx,
  output logic                       busy,
  output logic                       done
);

  sched_state_t        state;
  sched_state_t        state_nx;
  logic [15:0]         sweeps_q;
  logic [15:0]         sweep_cnt;
  logic [TANH_W-1:0]   t_q;
  logic [FIELD_W-1:0]  addr_q;
  logic [31:0]         lfsr_q;
  logic                lfsr_en;
  logic [FIELD_W-1:0]  field_sel;
  logic signed [31:0]  rnd;
  logic                last_idx;
  logic                last_sweep;
  logic                new_bit;

  pbit_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .q     (lfsr_q)
  );

  assign field_sel = field_in[int'(sel_idx)*FIELD_W +: FIELD_W];

  // The random number is bit 30 sign-extended over bits 30:0, giving a
  // uniform value in [-2^30, 2^30) to match the tanh full scale. Bit 31 is
  // discarded; writing it as q31 ^ (q31 ^ q30) keeps every LFSR bit read
  // while still evaluating to q30.
  assign rnd        = {lfsr_q[31] ^ (lfsr_q[31] ^ lfsr_q[30]), lfsr_q[30:0]};
  assign new_bit    = $signed(t_q) > rnd;
  assign last_idx   = (sel_idx == IDX_W'(N_PBITS - 1));
  assign last_sweep = (sweep_cnt == sweeps_q - 16'd1);

  // State register. Reset mid-run drops straight back to IDLE, so no done
  // pulse is produced for an aborted run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and Moore outputs. The LUT address is combinational in
  // LOOKUP so the tanh result arrives in the same cycle; in DECIDE the
  // captured address is replayed so the LUT input stays stable.
  always_comb begin
    state_nx  = state;
    tanh_addr = '0;
    lfsr_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (sweeps != 16'd0) ? LOOKUP : FIN;
        end
      end
      LOOKUP: begin
        busy      = 1'b1;
        tanh_addr = field_sel;
        lfsr_en   = 1'b1;
        state_nx  = DECIDE;
      end
      DECIDE: begin
        busy      = 1'b1;
        tanh_addr = addr_q;
        if (halt || (last_idx && last_sweep)) begin
          state_nx = FIN;
        end else begin
          state_nx = LOOKUP;
        end
      end
      FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath. The p-bit write happens in DECIDE even on halt; the index and
  // sweep counter only move when the run continues. m_out is never cleared
  // by a new run, only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweeps_q  <= '0;
      sweep_cnt <= '0;
      sel_idx   <= '0;
      t_q       <= '0;
      addr_q    <= '0;
      m_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (sweeps != 16'd0)) begin
            sweeps_q  <= sweeps;
            sweep_cnt <= '0;
            sel_idx   <= '0;
          end
        end
        LOOKUP: begin
          t_q    <= tanh_data;
          addr_q <= field_sel;
        end
        DECIDE: begin
          m_out[sel_idx] <= new_bit;
          if (!halt) begin
            if (last_idx) begin
              sel_idx   <= '0;
              sweep_cnt <= sweep_cnt + 16'd1;
            end else begin
              sel_idx <= sel_idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_update_sched.sv
// tb_pbit_update_sched
//   Directed bench for pbit_update_sched with N_PBITS=8. A small tanh table
//   stands in for the shared LUT, and a transaction-level model (LFSR step
//   per p-bit, compare, write) predicts every p-bit update and the exact
//   cycle on which done appears.
module tb_pbit_update_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic [15:0] sweeps;
  logic [47:0] field_in;
  logic [5:0]  tanh_addr;
  logic [31:0] tanh_data;
  logic [7:0]  m_out;
  logic [2:0]  sel_idx;
  logic        busy;
  logic        done;

  int passed = 0;
  int total  = 0;

  logic [7:0]  mModel;
  logic [31:0] lfsrModel;

  pbit_update_sched #(
    .N_PBITS   (8),
    .LFSR_SEED (32'h1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt      (halt),
    .sweeps    (sweeps),
    .field_in  (field_in),
    .tanh_addr (tanh_addr),
    .tanh_data (tanh_data),
    .m_out     (m_out),
    .sel_idx   (sel_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Stand-in tanh table: exact values for the two saturated fields used,
  // a coarse linear ramp elsewhere (field * 2^25).
  function automatic logic signed [31:0] lut(input logic [5:0] a);
    logic signed [31:0] v;
    case (a)
      6'h20:   v = -32'sd1073741582;
      6'h1F:   v = 32'sd1073741426;
      default: v = {{26{a[5]}}, a} <<< 25;
    endcase
    return v;
  endfunction

  assign tanh_data = lut(tanh_addr);

  function automatic logic [31:0] lfsrStep(input logic [31:0] q);
    logic [31:0] n;
    n = q >> 1;
    if (q[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      passed++;
    end
  endtask

  // Drive all fields to one value and pulse start over one rising edge.
  task automatic applyStimulus(input logic [5:0] fld, input int nsw);
    field_in = {8{fld}};
    sweeps   = nsw[15:0];
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Start a run and follow it cycle by cycle. mism counts any cycle where
  // index, address, busy/done or m_out disagree with the model. haltK >= 0
  // raises halt during the DECIDE of that p-bit in sweep 0 (and a decoy halt
  // in the preceding LOOKUP). busyStart pulses start in the middle of sweep 1.
  task automatic runModel(input int nsw, input logic [5:0] fld, input int haltK,
                          input bit busyStart, output int mism, output int doneAt,
                          output int ones);
    logic signed [31:0] t;
    logic signed [31:0] r;
    bit stop;
    int c;
    mism = 0;
    ones = 0;
    c    = 0;
    stop = 1'b0;
    applyStimulus(fld, nsw);
    for (int s = 0; s < nsw && !stop; s++) begin
      for (int k = 0; k < 8 && !stop; k++) begin
        @(negedge clk);
        c++;
        if (sel_idx !== 3'(k) || tanh_addr !== fld || busy !== 1'b1 ||
            done !== 1'b0 || m_out !== mModel) mism++;
        lfsrModel = lfsrStep(lfsrModel);
        t = lut(fld);
        if (busyStart && s == 1 && k == 2) start = 1'b1;
        if (haltK >= 0 && s == 0 && k == haltK - 1) halt = 1'b1;
        @(negedge clk);
        c++;
        start = 1'b0;
        if (sel_idx !== 3'(k) || tanh_addr !== fld || busy !== 1'b1 ||
            done !== 1'b0) mism++;
        halt = (haltK >= 0 && s == 0 && k == haltK);
        if (halt) stop = 1'b1;
        r = {lfsrModel[30], lfsrModel[30:0]};
        mModel[k] = (t > r);
        ones += (t > r) ? 1 : 0;
      end
    end
    @(negedge clk);
    c++;
    doneAt = c;
    halt   = 1'b0;
    if (done !== 1'b1 || m_out !== mModel) mism++;
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) mism++;
  endtask

  initial begin
    int mism;
    int doneAt;
    int ones;
    int seenDone;
    logic [7:0] prev;

    clk       = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    halt      = 1'b0;
    sweeps    = '0;
    field_in  = '0;
    mModel    = '0;
    lfsrModel = 32'h1;

    repeat (2) @(negedge clk);
    checkOutput("reset m_out", m_out, 8'h00);
    checkOutput("reset sel_idx", sel_idx, 3'd0);
    checkOutput("reset tanh_addr", tanh_addr, 6'h00);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] fields 0, 3 sweeps, start pulsed mid-run");
    runModel(3, 6'h00, -1, 1'b1, mism, doneAt, ones);
    checkOutput("t1 trace", mism, 0);
    checkOutput("t1 done cycle", doneAt, 49);

    $display("[TB] fields -8.0, 4 sweeps");
    runModel(4, 6'h20, -1, 1'b0, mism, doneAt, ones);
    checkOutput("t2a trace", mism, 0);
    checkOutput("t2a m_out", m_out, 8'h00);
    checkOutput("t2a done cycle", doneAt, 65);

    $display("[TB] fields +7.75, 4 sweeps");
    runModel(4, 6'h1F, -1, 1'b0, mism, doneAt, ones);
    checkOutput("t2b trace", mism, 0);
    checkOutput("t2b m_out", m_out, 8'hFF);

    $display("[TB] fields 0, 1000 sweeps");
    runModel(1000, 6'h00, -1, 1'b0, mism, doneAt, ones);
    checkOutput("t3 trace", mism, 0);
    checkOutput("t3 ones 45..55pct", (ones >= 3600 && ones <= 4400), 1'b1);

    $display("[TB] halt at p-bit 3 of sweep 0");
    prev = m_out;
    runModel(2, 6'h00, 3, 1'b0, mism, doneAt, ones);
    checkOutput("t4 trace", mism, 0);
    checkOutput("t4 done cycle", doneAt, 9);
    checkOutput("t4 m_out[7:4] held", m_out[7:4], prev[7:4]);
    checkOutput("t4 m_out[3]", m_out[3], mModel[3]);
    checkOutput("t4 idle busy", busy, 1'b0);

    $display("[TB] zero sweeps");
    prev = m_out;
    applyStimulus(6'h00, 0);
    @(negedge clk);
    checkOutput("t5 done", done, 1'b1);
    checkOutput("t5 m_out held", m_out, prev);
    @(negedge clk);
    checkOutput("t5 done cleared", done, 1'b0);

    $display("[TB] reset during LOOKUP of p-bit 5");
    applyStimulus(6'h1F, 2);
    repeat (11) @(negedge clk);
    checkOutput("t6 sel before reset", sel_idx, 3'd5);
    checkOutput("t6 addr before reset", tanh_addr, 6'h1F);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6 m_out", m_out, 8'h00);
    checkOutput("t6 sel_idx", sel_idx, 3'd0);
    checkOutput("t6 tanh_addr", tanh_addr, 6'h00);
    checkOutput("t6 busy", busy, 1'b0);
    checkOutput("t6 done", done, 1'b0);
    seenDone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) seenDone = 1;
    end
    checkOutput("t6 no done in reset", seenDone, 0);
    rst_n     = 1'b1;
    mModel    = '0;
    lfsrModel = 32'h1;
    @(negedge clk);
    runModel(1, 6'h1F, -1, 1'b0, mism, doneAt, ones);
    checkOutput("t6 rerun trace", mism, 0);
    checkOutput("t6 rerun done cycle", doneAt, 17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
